// File: rtl/control_unit.sv
// Main decoder of the 16-bit RISC core: maps the 4-bit opcode to registered
// datapath control signals, one clock after the opcode is presented.
module control_unit (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       stall,
    input  logic [3:0] opcode,
    output logic [2:0] alu_op,
    output logic       reg_wr,
    output logic       reg_dst,
    output logic       alu_src,
    output logic       jump,
    output logic       cmp,
    output logic       mem_rd,
    output logic       mem_wr,
    output logic       mem_to_reg
);

    typedef enum logic [3:0] {
        OP_ADD  = 4'h0,
        OP_SUB  = 4'h1,
        OP_AND  = 4'h2,
        OP_OR   = 4'h3,
        OP_XOR  = 4'h4,
        OP_SLL  = 4'h5,
        OP_SRL  = 4'h6,
        OP_ADDI = 4'h7,
        OP_LW   = 4'h8,
        OP_SW   = 4'h9,
        OP_BEQ  = 4'hA,
        OP_SLT  = 4'hB,
        OP_JMP  = 4'hC,
        OP_ANDI = 4'hD,
        OP_ORI  = 4'hE,
        OP_NOP  = 4'hF
    } opcode_e;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_XOR = 3'b100,
        ALU_SLL = 3'b101,
        ALU_SRL = 3'b110,
        ALU_SLT = 3'b111
    } alu_op_e;

    typedef struct packed {
        alu_op_e alu_op;
        logic    reg_wr;
        logic    reg_dst;
        logic    alu_src;
        logic    jump;
        logic    cmp;
        logic    mem_rd;
        logic    mem_wr;
        logic    mem_to_reg;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

    // Register-to-register ALU op writing rd.
    function automatic ctrl_t r_type(input alu_op_e op);
        ctrl_t c;
        c         = CTRL_NOP;
        c.alu_op  = op;
        c.reg_wr  = 1'b1;
        c.reg_dst = 1'b1;
        return c;
    endfunction

    // Immediate ALU op writing rt.
    function automatic ctrl_t i_type(input alu_op_e op);
        ctrl_t c;
        c         = CTRL_NOP;
        c.alu_op  = op;
        c.reg_wr  = 1'b1;
        c.alu_src = 1'b1;
        return c;
    endfunction

    ctrl_t decoded;
    ctrl_t ctrl_q;

    always_comb begin
        // NOTE: assigning the NOP word first keeps every path fully specified, so no latch is inferred.
        decoded = CTRL_NOP;
        if (!stall) begin
            // X/Z or unlisted opcodes fall through to the NOP default.
            case (opcode)
                OP_ADD:  decoded = r_type(ALU_ADD);
                OP_SUB:  decoded = r_type(ALU_SUB);
                OP_AND:  decoded = r_type(ALU_AND);
                OP_OR:   decoded = r_type(ALU_OR);
                OP_XOR:  decoded = r_type(ALU_XOR);
                OP_SLL:  decoded = r_type(ALU_SLL);
                OP_SRL:  decoded = r_type(ALU_SRL);
                OP_SLT:  decoded = r_type(ALU_SLT);
                OP_ADDI: decoded = i_type(ALU_ADD);
                OP_ANDI: decoded = i_type(ALU_AND);
                OP_ORI:  decoded = i_type(ALU_OR);
                OP_LW: begin
                    decoded            = i_type(ALU_ADD);
                    decoded.mem_rd     = 1'b1;
                    decoded.mem_to_reg = 1'b1;
                end
                OP_SW: begin
                    decoded.alu_src = 1'b1;
                    decoded.mem_wr  = 1'b1;
                end
                OP_BEQ: begin
                    decoded.alu_op = ALU_SUB;
                    decoded.cmp    = 1'b1;
                end
                OP_JMP:  decoded.jump = 1'b1;
                default: decoded = CTRL_NOP;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
        if (!rst_n) begin
            ctrl_q <= CTRL_NOP;
        end else begin
            ctrl_q <= decoded;
        end
    end

    assign alu_op     = ctrl_q.alu_op;
    assign reg_wr     = ctrl_q.reg_wr;
    assign reg_dst    = ctrl_q.reg_dst;
    assign alu_src    = ctrl_q.alu_src;
    assign jump       = ctrl_q.jump;
    assign cmp        = ctrl_q.cmp;
    assign mem_rd     = ctrl_q.mem_rd;
    assign mem_wr     = ctrl_q.mem_wr;
    assign mem_to_reg = ctrl_q.mem_to_reg;

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: directed vector table, async-reset
// sequences and randomized opcode/stall traffic against a rule-based model.
module tb_control_unit;

    logic       clk;
    logic       rst_n;
    logic       stall;
    logic [3:0] opcode;
    logic [2:0] alu_op;
    logic       reg_wr;
    logic       reg_dst;
    logic       alu_src;
    logic       jump;
    logic       cmp;
    logic       mem_rd;
    logic       mem_wr;
    logic       mem_to_reg;

    int n_cmp  = 0;
    int n_fail = 0;

    control_unit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .stall      (stall),
        .opcode     (opcode),
        .alu_op     (alu_op),
        .reg_wr     (reg_wr),
        .reg_dst    (reg_dst),
        .alu_src    (alu_src),
        .jump       (jump),
        .cmp        (cmp),
        .mem_rd     (mem_rd),
        .mem_wr     (mem_wr),
        .mem_to_reg (mem_to_reg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word layout: {alu_op[2:0], reg_wr, reg_dst, alu_src, jump, cmp, mem_rd, mem_wr, mem_to_reg}
    function automatic logic [10:0] outputs_word();
        return {alu_op, reg_wr, reg_dst, alu_src, jump, cmp, mem_rd, mem_wr, mem_to_reg};
    endfunction

    // Reference model built from instruction-class rules rather than a per-opcode table.
    function automatic logic [10:0] model(input logic st, input logic [3:0] op);
        int  code;
        bit  is_rtype, is_imm, is_load, is_store, is_branch, is_jump;
        logic [2:0] fn;
        code      = int'(op);
        is_rtype  = (code <= 6) || (code == 11);
        is_load   = (code == 8);
        is_store  = (code == 9);
        is_branch = (code == 10);
        is_jump   = (code == 12);
        is_imm    = (code == 7) || (code == 13) || (code == 14) || is_load;
        if (st || code == 15) return '0;
        if (code <= 6)      fn = op[2:0];
        else if (code == 11) fn = 3'd7;
        else if (is_branch)  fn = 3'd1;
        else if (code == 13) fn = 3'd2;
        else if (code == 14) fn = 3'd3;
        else                 fn = 3'd0;
        return {fn,
                logic'(is_rtype || is_imm),
                logic'(is_rtype),
                logic'(is_imm || is_store),
                logic'(is_jump),
                logic'(is_branch),
                logic'(is_load),
                logic'(is_store),
                logic'(is_load)};
    endfunction

    task automatic check(input string name, input logic [10:0] act, input logic [10:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic step(input logic st, input logic [3:0] op);
        stall  = st;
        opcode = op;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        stall;
        logic [3:0]  opcode;
        logic [10:0] exp;
    } vec_t;

    vec_t vecs[$];

    initial begin
        logic [10:0] viol;

        vecs = '{
            '{1'b0, 4'h0, 11'b000_11000000},   // ADD
            '{1'b0, 4'h1, 11'b001_11000000},   // SUB
            '{1'b0, 4'h2, 11'b010_11000000},   // AND
            '{1'b0, 4'h3, 11'b011_11000000},   // OR
            '{1'b0, 4'h4, 11'b100_11000000},   // XOR
            '{1'b0, 4'h5, 11'b101_11000000},   // SLL
            '{1'b0, 4'h6, 11'b110_11000000},   // SRL
            '{1'b0, 4'h7, 11'b000_10100000},   // ADDI
            '{1'b0, 4'h8, 11'b000_10100101},   // LW
            '{1'b0, 4'h9, 11'b000_00100010},   // SW
            '{1'b0, 4'hA, 11'b001_00001000},   // BEQ
            '{1'b0, 4'hB, 11'b111_11000000},   // SLT
            '{1'b0, 4'hC, 11'b000_00010000},   // JMP
            '{1'b0, 4'hD, 11'b010_10100000},   // ANDI
            '{1'b0, 4'hE, 11'b011_10100000},   // ORI
            '{1'b0, 4'hF, 11'b000_00000000},   // NOP
            '{1'b0, 4'h0, 11'b000_11000000},   // back to ADD
            '{1'b1, 4'h7, 11'b000_00000000},   // stalled ADDI
            '{1'b0, 4'h7, 11'b000_10100000},   // ADDI after stall drops
            '{1'b1, 4'h8, 11'b000_00000000},   // stalled LW
            '{1'b0, 4'h8, 11'b000_10100101}    // LW, left in place for reset test
        };

        rst_n  = 1'b0;
        stall  = 1'b0;
        opcode = 4'h0;
        #2;
        check("reset_no_edge", outputs_word(), 11'b0);

        #5;
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            step(vecs[i].stall, vecs[i].opcode);
            check($sformatf("vec%0d_op%h_st%0d", i, vecs[i].opcode, vecs[i].stall),
                  outputs_word(), vecs[i].exp);
        end

        // Async reset mid-run while LW is showing: must clear between edges.
        #3;
        rst_n = 1'b0;
        #1;
        check("async_clear", outputs_word(), 11'b0);
        #2;
        rst_n = 1'b1;
        #2;
        check("hold_after_release", outputs_word(), 11'b0);
        @(posedge clk);
        #1;
        check("restore_lw", outputs_word(), 11'b000_10100101);

        for (int i = 0; i < 300; i++) begin
            logic       st;
            logic [3:0] op;
            st = ($urandom_range(0, 3) == 0);
            op = 4'($urandom_range(0, 15));
            step(st, op);
            check($sformatf("rand%0d_op%h_st%0d", i, op, st), outputs_word(), model(st, op));
            viol = {10'b0, (mem_rd & mem_wr) | (mem_to_reg & ~mem_rd) | (jump & cmp) |
                           (reg_wr & (mem_wr | jump | cmp))};
            check($sformatf("invariant%0d", i), viol, 11'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
